// File: rtl/mult_pkg.sv
// mult_pkg: state encoding and counter sizing shared by the sequential multiplier.
package mult_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, CALC = ST_CALC, FIN = ST_FIN} state_t;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add multiplier, one multiplier bit per cycle, signed/unsigned per op.
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = cnt_w(WIDTH);
  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mc;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mb;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;
  // magnitude of the most-negative value wraps to 2^(W-1), still correct as unsigned
  assign w_abs_a = (signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign w_abs_b = (signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  assign w_sum   = r_mb[0] ? r_acc + r_mc : r_acc;
  assign w_last  = (r_cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && ((r_mb >> 1) == '0));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mc    <= '0;
      r_acc   <= '0;
      r_mb    <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_mc    <= {{WIDTH{1'b0}}, w_abs_a};
          r_mb    <= w_abs_b;
          r_neg   <= signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
          r_acc   <= '0;
          r_cnt   <= '0;
          busy    <= 1'b1;
          r_state <= CALC;
        end
        CALC: begin
          r_acc   <= w_sum;
          r_mc    <= r_mc << 1;
          r_mb    <= r_mb >> 1;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= w_last ? FIN : CALC;
        end
        FIN: begin
          product <= r_neg ? -r_acc : r_acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
